// File: rtl/anim_defs_pkg.sv
// Shared definitions for the animation plotting path: screen geometry,
// colour width, plotter FSM encoding, latched request payload and the
// sprite image used by sprite_rom (built with SPRITE_PLOTTER_ROM_EN).
package anim_defs;

  localparam int unsigned SCR_W    = 160;
  localparam int unsigned SCR_H    = 120;
  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned PX_W     = X_W + 1;
  localparam int unsigned REQ_Y_W  = 6;
  localparam int unsigned VGA_Y_W  = 7;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned ROM_AW   = 2 * CNT_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Request captured on acceptance
  typedef struct packed {
    logic [X_W-1:0]     x;
    logic [REQ_Y_W-1:0] y;
    logic               erase;
  } req_t;

  // Sprite image addressed by {row, col}; 0 is transparent (row 3, col 2)
  function automatic logic [COLOUR_W-1:0] rom_pixel(input logic [ROM_AW-1:0] addr);
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic [CNT_W:0]   sum;
    row = addr[ROM_AW-1:CNT_W];
    col = addr[CNT_W-1:0];
    sum = (CNT_W+1)'(row) + (CNT_W+1)'(col);
    if (row == CNT_W'(3) && col == CNT_W'(2)) begin
      return '0;
    end
    return COLOUR_W'(sum % (CNT_W+1)'(7)) + COLOUR_W'(1);
  endfunction

endpackage

// File: rtl/sprite_plotter_rom.sv
// sprite_rom: synchronous 1-cycle sprite image lookup.
// Only compiled when SPRITE_PLOTTER_ROM_EN is defined.
//  clk, resetn : clock, async active-low reset
//  addr        : {row, col} pixel address
//  pix_q       : pixel colour, valid the cycle after addr
`ifdef SPRITE_PLOTTER_ROM_EN
module sprite_rom
  import anim_defs::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic [ROM_AW-1:0]   addr,
  output logic [COLOUR_W-1:0] pix_q
);

  logic [COLOUR_W-1:0] pix_d;

  always_comb begin
    pix_d = rom_pixel(addr);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pix_q <= '0;
    else         pix_q <= pix_d;
  end

endmodule
`endif

// File: rtl/sprite_plotter.sv
// sprite_plotter: accepts one draw/erase request per handshake and walks a
// SPR_W x SPR_H box one pixel per clock into the VGA adapter write port,
// pulsing done when the box is finished.
// Macro SPRITE_PLOTTER_ROM_EN: colour from sprite_rom with transparency;
// otherwise a solid FG_COLOUR box.
//  clk, resetn                  : clock, async active-low reset
//  req, req_x, req_y, req_erase : request handshake (accepted on req && ready)
//  ready                        : high only while idle
//  done                         : one-cycle pulse after last pixel
//  vga_x, vga_y, vga_colour     : pixel to the VGA adapter
//  vga_plot                     : write strobe
module sprite_plotter
  import anim_defs::*;
#(
  parameter int unsigned         SPR_W     = 8,
  parameter int unsigned         SPR_H     = 8,
  parameter logic [COLOUR_W-1:0] FG_COLOUR = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req,
  input  logic [X_W-1:0]      req_x,
  input  logic [REQ_Y_W-1:0]  req_y,
  input  logic                req_erase,
  output logic                ready,
  output logic                done,
  output logic [X_W-1:0]      vga_x,
  output logic [VGA_Y_W-1:0]  vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  state_e              state_q, state_d;
  req_t                lat_q, lat_d;
  logic [CNT_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    row_q, row_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [VGA_Y_W-1:0]  vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;

  logic [PX_W-1:0]     px_c;
  logic [VGA_Y_W-1:0]  py_c;
  logic                on_screen_c;
  logic                last_col_c;
  logic                last_row_c;

`ifdef SPRITE_PLOTTER_ROM_EN
  logic [COLOUR_W-1:0] rom_pix;

  // Addressed with the next count so data lines up with the current count
  sprite_rom u_rom (
    .clk    (clk),
    .resetn (resetn),
    .addr   ({row_d, col_d}),
    .pix_q  (rom_pix)
  );
`endif

  // Screen coordinates of the current count and clip test
  always_comb begin
    px_c        = {1'b0, lat_q.x} + PX_W'(col_q);
    py_c        = {1'b0, lat_q.y} + VGA_Y_W'(row_q);
    on_screen_c = (px_c < PX_W'(SCR_W)) && (py_c < VGA_Y_W'(SCR_H));
    last_col_c  = (col_q == CNT_W'(SPR_W - 1));
    last_row_c  = (row_q == CNT_W'(SPR_H - 1));
  end

  // Next state, counters and registered outputs
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    col_d    = col_q;
    row_d    = row_q;
    vga_x_d  = vga_x_q;
    vga_y_d  = vga_y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req && ready_q) begin
          lat_d   = '{x: req_x, y: req_y, erase: req_erase};
          col_d   = '0;
          row_d   = '0;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        vga_x_d = px_c[X_W-1:0];
        vga_y_d = py_c;
`ifdef SPRITE_PLOTTER_ROM_EN
        colour_d = lat_q.erase ? BG_COLOUR : rom_pix;
        plot_d   = on_screen_c && (lat_q.erase || (rom_pix != '0));
`else
        colour_d = lat_q.erase ? BG_COLOUR : FG_COLOUR;
        plot_d   = on_screen_c;
`endif
        if (last_col_c) begin
          col_d = '0;
          if (last_row_c) state_d = S_DONE;
          else            row_d   = row_q + CNT_W'(1);
        end else begin
          col_d = col_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        // Last pixel is already on the port; done follows one cycle later
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Stay not-ready through the done pulse so back-to-back requests wait
    ready_d = (state_d == S_IDLE) && (state_q != S_DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      lat_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      col_q    <= col_d;
      row_q    <= row_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      vga_x_q  <= vga_x_d;
      vga_y_q  <= vga_y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
    end
  end

  assign ready      = ready_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = colour_q;
  assign vga_plot   = plot_q;

endmodule

// File: tb/tb_sprite_plotter.sv
// Scoreboard bench for sprite_plotter (8x8 sprite). Honours
// SPRITE_PLOTTER_ROM_EN for the sprite image and transparency.
module tb_sprite_plotter;

  localparam int SW = 8;
  localparam int SH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       req = 1'b0;
  logic [7:0] req_x = '0;
  logic [5:0] req_y = '0;
  logic       req_erase = 1'b0;
  logic       ready, done, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int plots_seen = 0;
  int busy_lo = -1;
  int busy_hi = -2;
  logic [17:0] pix_q[$];
  int          done_q[$];

  sprite_plotter dut (
    .clk        (clk),
    .resetn     (resetn),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_erase  (req_erase),
    .ready      (ready),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sprite image as drawn by the artist: colour cycles 1..7 along diagonals,
  // with one transparent pixel at column 2, row 3
  function automatic int sprite_img(input int c, input int r);
    if (c == 2 && r == 3) return 0;
    return ((c + r) % 7) + 1;
  endfunction

  // Reference model: every visible pixel of the box, row-major
  function automatic void push_box(input int x, input int y, input bit e);
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        int px = x + c;
        int py = y + r;
        int col = e ? 0 : 7;
        bit vis = (px < 160) && (py < 120);
`ifdef SPRITE_PLOTTER_ROM_EN
        if (!e) begin
          col = sprite_img(c, r);
          if (col == 0) vis = 1'b0;
        end
`endif
        if (vis) pix_q.push_back({8'(px), 7'(py), 3'(col)});
      end
    end
  endfunction

  // Monitor: pops and compares whenever the DUT presents a pixel or done
  always @(negedge clk) begin
    if (resetn) begin
      if (vga_plot === 1'b1) begin
        plots_seen++;
        if (pix_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_plot actual=(%0d,%0d,%0d) required=no plot", vga_x, vga_y, vga_colour);
        end else begin
          logic [17:0] exp_pix;
          exp_pix = pix_q.pop_front();
          chk("pixel", 32'({vga_x, vga_y, vga_colour}), 32'(exp_pix));
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          int exp_cyc;
          exp_cyc = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(exp_cyc));
        end
      end
      if (cyc >= busy_lo && cyc <= busy_hi) chk("ready_busy", 32'(ready), 32'(0));
    end
  end

  // Wait for ready, present the request, queue expectations
  task automatic issue(input logic [7:0] x, input logic [5:0] y, input logic e, output int n);
    bit ok = 1'b0;
    n = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("ready_timeout", 32'(ready), 32'(1));
    end else begin
      req = 1'b1;
      req_x = x;
      req_y = y;
      req_erase = e;
      n = cyc;
      push_box(int'(x), int'(y), e);
      done_q.push_back(n + 66);
      busy_lo = n + 1;
      busy_hi = n + 66;
      @(negedge clk);
      req = 1'b0;
      // Scrambled inputs after acceptance must not affect the box
      req_x = 8'($urandom);
      req_y = 6'($urandom);
      req_erase = 1'($urandom);
    end
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pix_q.size() == 0 && done_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'(1));
  endtask

  initial begin
    int n1, n2, p0;

    // Reset state
    #25;
    chk("rst_ready", 32'(ready), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_plot", 32'(vga_plot), 32'(0));
    chk("rst_xy", 32'({vga_x, vga_y}), 32'(0));
    @(negedge clk);
    resetn = 1'b1;

    // Plain box
    issue(8'd10, 6'd20, 1'b0, n1);
    drain();

    // Right-edge clipping: only x 156..159 visible
    p0 = plots_seen;
    issue(8'd156, 6'd60, 1'b0, n1);
    drain();
`ifdef SPRITE_PLOTTER_ROM_EN
    chk("clip_count", 32'(plots_seen - p0), 32'(31));
`else
    chk("clip_count", 32'(plots_seen - p0), 32'(32));
`endif

    // Erase with a second request held high throughout the draw
    issue(8'd0, 6'd0, 1'b1, n1);
    req = 1'b1;
    req_x = 8'd5;
    req_y = 6'd5;
    req_erase = 1'b0;
    issue(8'd5, 6'd5, 1'b0, n2);
    chk("b2b_gap", 32'(n2 >= n1 + 67), 32'(1));
    drain();

    // Transparency then full erase of the same box
    p0 = plots_seen;
    issue(8'd20, 6'd20, 1'b0, n1);
    issue(8'd20, 6'd20, 1'b1, n2);
    drain();
`ifdef SPRITE_PLOTTER_ROM_EN
    chk("rom_plots", 32'(plots_seen - p0), 32'(127));
`else
    chk("rom_plots", 32'(plots_seen - p0), 32'(128));
`endif

    // Randomized requests including off-screen right edges
    for (int k = 0; k < 10; k++) begin
      issue(8'($urandom_range(0, 255)), 6'($urandom_range(0, 63)), 1'($urandom), n1);
    end
    drain();

    // Reset in the middle of a draw
    p0 = plots_seen;
    issue(8'd40, 6'd10, 1'b0, n1);
    for (int i = 0; i < 200 && (plots_seen - p0) < 30; i++) @(negedge clk);
    chk("mid_plots", 32'(plots_seen - p0), 32'(30));
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_plot", 32'(vga_plot), 32'(0));
    chk("mid_rst_xy", 32'({vga_x, vga_y, vga_colour}), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    pix_q.delete();
    done_q.delete();
    busy_lo = -1;
    busy_hi = -2;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ready), 32'(1));
    repeat (80) @(negedge clk);

    // Box after reset still correct
    issue(8'd100, 6'd50, 1'b0, n1);
    drain();

    chk("pix_left", 32'(pix_q.size()), 32'(0));
    chk("done_left", 32'(done_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
